// File: rtl/nco_rx_pkg.sv
// Shared types, default constants and the count-to-symbol helper for the NCO FSK receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nco_rx_pkg;

  localparam int SAMPLE_W  = 4;    // DAC sample width
  localparam int WINDOW    = 256;  // clocks per symbol window
  localparam int CNT_W     = 9;    // saturating crossing counter width
  localparam int HI_TH     = 9;    // slicer sets at sample >= HI_TH
  localparam int LO_TH     = 6;    // slicer clears at sample <= LO_TH
  localparam int SYM_SHIFT = 4;    // log2(crossings per symbol unit)
  localparam int SYM_W     = 4;    // recovered symbol width

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ALIGN,
    COUNT
  } rx_state_t;

  // Round the crossing count to the nearest symbol unit, then clamp to the
  // largest symbol the output can carry. shift must be at least 1.
  function automatic int unsigned round_sym(input int unsigned count,
                                            input int          shift,
                                            input int          sym_w);
    int unsigned v;
    int unsigned max_sym;
    v       = (count + (32'd1 << (shift - 1))) >> shift;
    max_sym = (32'd1 << sym_w) - 32'd1;
    return (v > max_sym) ? max_sym : v;
  endfunction

endpackage

// File: rtl/nco_fsk_receiver_if.sv
// Recovered-symbol stream: symbol, raw crossing count, valid/ready handshake.
// Latency: n/a (wiring only).
// Backpressure: producer holds sym_data/sym_count stable while sym_valid=1 and sym_ready=0.
// Ports: sym_data, sym_count, sym_valid driven by master; sym_ready driven by slave.
interface nco_fsk_receiver_if #(
  parameter int SYM_W = nco_rx_pkg::SYM_W,
  parameter int CNT_W = nco_rx_pkg::CNT_W
);

  logic [SYM_W-1:0] sym_data;
  logic [CNT_W-1:0] sym_count;
  logic             sym_valid;
  logic             sym_ready;

  modport master (
    output sym_data,
    output sym_count,
    output sym_valid,
    input  sym_ready
  );

  modport slave (
    input  sym_data,
    input  sym_count,
    input  sym_valid,
    output sym_ready
  );

endinterface

// File: rtl/nco_rx_slicer.sv
// Hysteresis comparator on the DAC sample plus rising-crossing detect.
// Latency: slice_q is registered (1 clock); crossing is combinational from the current sample.
// Backpressure: none, runs every clock regardless of receiver state.
// Ports: clk, reset (async active-low), sample in; slice_q (registered level), crossing (0->1 this edge) out.
module nco_rx_slicer
  import nco_rx_pkg::*;
#(
  parameter int P_SAMPLE_W = SAMPLE_W,
  parameter int P_HI_TH    = HI_TH,
  parameter int P_LO_TH    = LO_TH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [P_SAMPLE_W-1:0] sample,
  output logic                  slice_q,
  output logic                  crossing
);

  localparam logic [P_SAMPLE_W-1:0] HI = P_SAMPLE_W'(P_HI_TH);
  localparam logic [P_SAMPLE_W-1:0] LO = P_SAMPLE_W'(P_LO_TH);

  logic next_slice;

  // Between the thresholds the previous level is held, which rejects small
  // ripple around mid-scale.
  always_comb begin
    next_slice = slice_q;
    if (sample >= HI) begin
      next_slice = 1'b1;
    end else if (sample <= LO) begin
      next_slice = 1'b0;
    end
  end

  // A crossing is reported on the same edge that the slicer flips high, so the
  // counter can include the sample being consumed on that edge.
  assign crossing = next_slice & ~slice_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slice_q <= 1'b0;
    end else begin
      slice_q <= next_slice;
    end
  end

endmodule

// File: rtl/nco_fsk_receiver.sv
// FSK receiver: counts slicer rising crossings per WINDOW-clock symbol window and maps the count to a symbol.
// Latency: result presented 1 clock after the window's last sample.
// Backpressure: if a held result is not taken by the next window end, the new one is dropped and overrun sticks.
// Ports: clk, reset (async active-low), en, align (window start strobe), sample in;
//        sym (master: sym_data, sym_count, sym_valid / sym_ready), overrun, locked out.
module nco_fsk_receiver
  import nco_rx_pkg::*;
#(
  parameter int P_SAMPLE_W  = SAMPLE_W,
  parameter int P_WINDOW    = WINDOW,
  parameter int P_CNT_W     = CNT_W,
  parameter int P_HI_TH     = HI_TH,
  parameter int P_LO_TH     = LO_TH,
  parameter int P_SYM_SHIFT = SYM_SHIFT,
  parameter int P_SYM_W     = SYM_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  align,
  input  logic [P_SAMPLE_W-1:0] sample,
  nco_fsk_receiver_if.master    sym,
  output logic                  overrun,
  output logic                  locked
);

  localparam int                   WIN_W    = $clog2(P_WINDOW);
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(P_WINDOW - 1);
  localparam logic [P_CNT_W-1:0]   CNT_MAX  = {P_CNT_W{1'b1}};

  rx_state_t            state;
  logic [WIN_W-1:0]     win_cnt;     // index of the sample consumed on the next edge
  logic [P_CNT_W-1:0]   cross_cnt;   // crossings seen so far in this window
  logic                 pend_vld;    // completed window waiting to reach the output
  logic [P_CNT_W-1:0]   pend_cnt;
  logic [P_SYM_W-1:0]   pend_sym;
  logic [P_CNT_W-1:0]   cnt_inc;
  logic [P_CNT_W-1:0]   cnt_first;
  logic                 crossing;
  logic                 slice_q_unused;  // only the rising edge matters here

  nco_rx_slicer #(
    .P_SAMPLE_W (P_SAMPLE_W),
    .P_HI_TH    (P_HI_TH),
    .P_LO_TH    (P_LO_TH)
  ) u_slicer (
    .clk      (clk),
    .reset    (reset),
    .sample   (sample),
    .slice_q  (slice_q_unused),
    .crossing (crossing)
  );

  // Count including the sample on this edge, saturating at all-ones.
  assign cnt_inc   = (crossing && (cross_cnt != CNT_MAX)) ? cross_cnt + 1'b1 : cross_cnt;
  // Count for a window whose index-0 sample is consumed on this edge.
  assign cnt_first = {{(P_CNT_W-1){1'b0}}, crossing};
  assign pend_sym  = P_SYM_W'(round_sym(32'(pend_cnt), P_SYM_SHIFT, P_SYM_W));

  assign locked = (state == COUNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      win_cnt       <= '0;
      cross_cnt     <= '0;
      pend_vld      <= 1'b0;
      pend_cnt      <= '0;
      sym.sym_data  <= '0;
      sym.sym_count <= '0;
      sym.sym_valid <= 1'b0;
      overrun       <= 1'b0;
    end else if (!en) begin
      // Disable abandons the window and any undelivered result; the last
      // delivered symbol/count stay visible.
      state         <= IDLE;
      win_cnt       <= '0;
      cross_cnt     <= '0;
      pend_vld      <= 1'b0;
      sym.sym_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      // Output stage: a finished window loads only if the slot is free or is
      // being emptied on this same edge.
      if (pend_vld) begin
        if (!sym.sym_valid || sym.sym_ready) begin
          sym.sym_valid <= 1'b1;
          sym.sym_data  <= pend_sym;
          sym.sym_count <= pend_cnt;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sym.sym_valid && sym.sym_ready) begin
        sym.sym_valid <= 1'b0;
      end
      pend_vld <= 1'b0;

      case (state)
        IDLE: begin
          state <= WAIT_ALIGN;
        end
        WAIT_ALIGN: begin
          if (align) begin
            state     <= COUNT;
            win_cnt   <= WIN_W'(1);
            cross_cnt <= cnt_first;
          end
        end
        COUNT: begin
          if (align) begin
            // Re-alignment throws away the partial window silently.
            win_cnt   <= WIN_W'(1);
            cross_cnt <= cnt_first;
          end else if (win_cnt == WIN_LAST) begin
            pend_vld  <= 1'b1;
            pend_cnt  <= cnt_inc;
            win_cnt   <= '0;
            cross_cnt <= '0;
          end else begin
            win_cnt   <= win_cnt + 1'b1;
            cross_cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_fsk_receiver.sv
// Self-checking bench for nco_fsk_receiver: window-level reference model checked every clock,
// plus hand-computed expectations for the directed scenarios.
// Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge or on the falling edge.
module tb_nco_fsk_receiver;

  logic       clk;
  logic       reset;
  logic       en;
  logic       align;
  logic [3:0] sample;
  logic       overrun;
  logic       locked;

  nco_fsk_receiver_if sym_if ();

  nco_fsk_receiver dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .align   (align),
    .sample  (sample),
    .sym     (sym_if),
    .overrun (overrun),
    .locked  (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total  = 0;
  int n_passed = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- stimulus generator ----------------
  int         mode;     // 0 const 0, 1 square 8/8, 2 NCO sawtooth, 3 toggle 7/8, 4 toggle 0/15
  int         gi;
  int         nco_f;
  logic [9:0] ph;

  task automatic cyc();
    @(negedge clk);
    gi++;
    ph = ph + 10'(nco_f);
    case (mode)
      1:       sample = ((gi % 16) < 8) ? 4'd15 : 4'd0;
      2:       sample = ph[9:6];
      3:       sample = gi[0] ? 4'd8 : 4'd7;
      4:       sample = gi[0] ? 4'd15 : 4'd0;
      default: sample = 4'd0;
    endcase
  endtask

  task automatic restart();
    en = 1'b0;
    cyc();
    en = 1'b1;
    cyc();
  endtask

  task automatic pulse_align();
    align = 1'b1;
    cyc();
    align = 1'b0;
  endtask

  // Align so that index 0 is the first high sample of the square wave.
  task automatic sq_align();
    repeat (8) cyc();
    while ((gi % 16) != 0) cyc();
    pulse_align();
  endtask

  // Clocks from the align edge (counted as 1) until sym_valid is seen.
  task automatic wait_valid(output int n);
    n = 1;
    while (!sym_if.sym_valid && n < 600) begin
      cyc();
      n++;
    end
    if (!sym_if.sym_valid) chk("valid_timeout", 0, 1);
  endtask

  // ---------------- reference model ----------------
  function automatic int exp_sym(input int c);
    int v;
    v = (c + 8) >> 4;
    return (v > 15) ? 15 : v;
  endfunction

  int m_slice, m_state, m_pv, m_pc, m_vld, m_ovr, m_data, m_cnt, m_sum;
  int nx, cr;
  int m_q[$];   // crossing flags of the window in progress, one per sample

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_slice = 0; m_state = 0; m_pv = 0; m_pc = 0;
        m_vld = 0; m_ovr = 0; m_data = 0; m_cnt = 0;
        m_q.delete();
      end else begin
        nx = (sample >= 4'd9) ? 1 : (sample <= 4'd6) ? 0 : m_slice;
        cr = (nx == 1 && m_slice == 0) ? 1 : 0;
        m_slice = nx;
        if (!en) begin
          m_state = 0; m_vld = 0; m_ovr = 0; m_pv = 0;
          m_q.delete();
        end else begin
          if (m_pv == 1) begin
            if (m_vld == 0 || sym_if.sym_ready) begin
              m_vld = 1; m_cnt = m_pc; m_data = exp_sym(m_pc);
            end else begin
              m_ovr = 1;
            end
          end else if (m_vld == 1 && sym_if.sym_ready) begin
            m_vld = 0;
          end
          m_pv = 0;
          if (m_state == 0) begin
            m_state = 1;
          end else if (align) begin
            m_state = 2;
            m_q.delete();
            m_q.push_back(cr);
          end else if (m_state == 2) begin
            m_q.push_back(cr);
            if (m_q.size() == 256) begin
              m_sum = 0;
              foreach (m_q[i]) m_sum += m_q[i];
              m_pc = (m_sum > 511) ? 511 : m_sum;
              m_pv = 1;
              m_q.delete();
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("sym_valid", int'(sym_if.sym_valid), m_vld);
      chk("sym_data",  int'(sym_if.sym_data),  m_data);
      chk("sym_count", int'(sym_if.sym_count), m_cnt);
      chk("overrun",   int'(overrun),          m_ovr);
      chk("locked",    int'(locked),           (m_state == 2) ? 1 : 0);
    end
  end

  // ---------------- directed scenarios ----------------
  int lat;

  initial begin
    reset = 1'b0; en = 1'b0; align = 1'b0; sample = 4'd0;
    sym_if.sym_ready = 1'b1;
    mode = 0; gi = 0; nco_f = 0; ph = '0;
    repeat (2) cyc();
    chk("rst_valid",   int'(sym_if.sym_valid), 0);
    chk("rst_data",    int'(sym_if.sym_data),  0);
    chk("rst_count",   int'(sym_if.sym_count), 0);
    chk("rst_overrun", int'(overrun),          0);
    chk("rst_locked",  int'(locked),           0);
    reset = 1'b1;
    cyc();

    // Period-16 square wave: 16 crossings -> symbol 1, valid 257 clocks after align.
    mode = 1;
    restart();
    sq_align();
    chk("sq_locked", int'(locked), 1);
    wait_valid(lat);
    chk("sq_latency", lat, 257);
    chk("sq_count", int'(sym_if.sym_count), 16);
    chk("sq_data",  int'(sym_if.sym_data),  1);

    // Transmitter loopback: symbol 3 (F=192), 15 (F=960 aliases to 16), 0.
    mode = 2; nco_f = 192; ph = '0;
    restart(); repeat (40) cyc(); pulse_align(); wait_valid(lat);
    chk("lb3_count", int'(sym_if.sym_count), 48);
    chk("lb3_data",  int'(sym_if.sym_data),  3);
    nco_f = 960; ph = '0;
    restart(); repeat (40) cyc(); pulse_align(); wait_valid(lat);
    chk("lb15_count", int'(sym_if.sym_count), 16);
    chk("lb15_data",  int'(sym_if.sym_data),  1);
    nco_f = 0; ph = '0;
    restart(); repeat (40) cyc(); pulse_align(); wait_valid(lat);
    chk("lb0_count", int'(sym_if.sym_count), 0);
    chk("lb0_data",  int'(sym_if.sym_data),  0);

    // Ripple inside the hysteresis band never crosses.
    mode = 3;
    restart(); repeat (20) cyc(); pulse_align(); wait_valid(lat);
    chk("hys_count", int'(sym_if.sym_count), 0);
    chk("hys_data",  int'(sym_if.sym_data),  0);

    // Full-swing toggle every clock: 128 crossings -> symbol 8.
    mode = 4;
    restart(); repeat (20) cyc(); pulse_align(); wait_valid(lat);
    chk("fast_count", int'(sym_if.sym_count), 128);
    chk("fast_data",  int'(sym_if.sym_data),  8);

    // Consumer stalled across two window ends: first result held, overrun set.
    mode = 1;
    sym_if.sym_ready = 1'b0;
    restart(); sq_align(); wait_valid(lat);
    chk("ovr_latency", lat, 257);
    repeat (256) cyc();
    chk("ovr_flag",  int'(overrun),          1);
    chk("ovr_valid", int'(sym_if.sym_valid), 1);
    chk("ovr_count", int'(sym_if.sym_count), 16);

    // Ready only on the second window-end load edge: new result loads, no overrun.
    restart(); sq_align(); wait_valid(lat);
    repeat (255) cyc();
    sym_if.sym_ready = 1'b1;
    cyc();
    sym_if.sym_ready = 1'b0;
    chk("rdy_edge_overrun", int'(overrun),          0);
    chk("rdy_edge_valid",   int'(sym_if.sym_valid), 1);
    chk("rdy_edge_count",   int'(sym_if.sym_count), 16);
    sym_if.sym_ready = 1'b1;
    cyc();
    chk("rdy_drain_valid", int'(sym_if.sym_valid), 0);

    // Re-align at index 100: partial window discarded, next result 257 clocks after it.
    restart(); sq_align();
    repeat (99) cyc();
    pulse_align();
    wait_valid(lat);
    chk("realign_latency", lat, 257);
    chk("realign_count", int'(sym_if.sym_count), 16);

    // Asynchronous reset mid-window, then recover with a fresh align.
    restart(); sq_align();
    repeat (199) cyc();
    chk("pre_rst_locked", int'(locked), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_valid",  int'(sym_if.sym_valid), 0);
    chk("async_rst_data",   int'(sym_if.sym_data),  0);
    chk("async_rst_count",  int'(sym_if.sym_count), 0);
    chk("async_rst_locked", int'(locked),           0);
    repeat (3) cyc();
    reset = 1'b1;
    sq_align();
    wait_valid(lat);
    chk("post_rst_latency", lat, 257);
    chk("post_rst_data",  int'(sym_if.sym_data),  1);
    chk("post_rst_count", int'(sym_if.sym_count), 16);

    repeat (2) cyc();
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
